// File: rtl/playfield_pkg.sv
// rtl/playfield_pkg.sv - playfield register map, mode bits and render states
package playfield_pkg;

    localparam logic [5:0] ADDR_PF0      = 6'h00;
    localparam logic [5:0] ADDR_PF1      = 6'h01;
    localparam logic [5:0] ADDR_PF2      = 6'h02;
    localparam logic [5:0] ADDR_MODE     = 6'h03;
    localparam logic [5:0] ADDR_FG_R     = 6'h04;
    localparam logic [5:0] ADDR_BORDER_B = 6'h0c;
    localparam logic [5:0] ADDR_STATUS   = 6'h0d;

    localparam int MODE_REFLECT   = 0;
    localparam int MODE_IMMEDIATE = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BORDER_L,
        ST_LEFT,
        ST_RIGHT,
        ST_BORDER_R
    } pf_state_t;

endpackage

// File: rtl/playfield_timing.sv
// rtl/playfield_timing.sv - line FSM with sub-pixel and playfield bit-index counters
module playfield_timing
    import playfield_pkg::*;
#(
    parameter int PF_BITS   = 22,
    parameter int BIT_WIDTH = 16,
    parameter int BORDER    = 8,
    parameter int HPOS_W    = 10,
    parameter int IDX_W     = (PF_BITS > 1) ? $clog2(PF_BITS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [HPOS_W-1:0] hpos,
    input  logic              in_image,
    input  logic              reflect,
    output pf_state_t         state,
    output logic [IDX_W-1:0]  bit_idx
);

    localparam int SUB_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam int BRD_W = (BORDER > 1) ? $clog2(BORDER) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIT_WIDTH - 1);
    localparam logic [BRD_W-1:0] BRD_LAST = BRD_W'(BORDER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PF_BITS - 1);

    logic [SUB_W-1:0] sub_cnt;
    logic [BRD_W-1:0] brd_cnt;
    logic             dir_down;
    logic [IDX_W-1:0] right_end;

    // The right half ends on bit 0 when mirrored, on the last bit otherwise
    assign right_end = dir_down ? '0 : IDX_LAST;

    // Line sequencer: border, left half, right half, border; in_image low aborts to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sub_cnt  <= '0;
            brd_cnt  <= '0;
            bit_idx  <= '0;
            dir_down <= 1'b0;
        end else if (!in_image) begin
            state    <= ST_IDLE;
            sub_cnt  <= '0;
            brd_cnt  <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hpos == '0) begin
                        state   <= ST_BORDER_L;
                        brd_cnt <= '0;
                    end
                end
                ST_BORDER_L: begin
                    if (brd_cnt == BRD_LAST) begin
                        state   <= ST_LEFT;
                        brd_cnt <= '0;
                        sub_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        brd_cnt <= brd_cnt + 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state    <= ST_RIGHT;
                            dir_down <= reflect;
                            bit_idx  <= reflect ? IDX_LAST : '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt <= '0;
                        if (bit_idx == right_end) begin
                            state   <= ST_BORDER_R;
                            bit_idx <= '0;
                        end else if (dir_down) begin
                            bit_idx <= bit_idx - 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
                ST_BORDER_R: begin
                    state <= ST_BORDER_R;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/playfield_gen.sv
// rtl/playfield_gen.sv - playfield registers, vblank-synchronised update and colour mux; PLAYFIELD_READBACK_EN enables register readback
module playfield_gen
    import playfield_pkg::*;
#(
    parameter int PF_BITS   = 22,
    parameter int BIT_WIDTH = 16,
    parameter int BORDER    = 8,
    parameter int HPOS_W    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              write_enable,
    input  logic [5:0]        address,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    input  logic [HPOS_W-1:0] hpos,
    input  logic              in_image,
    input  logic              in_vblank,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue
);

    localparam int IDX_W = (PF_BITS > 1) ? $clog2(PF_BITS) : 1;

    logic [23:0]      shadow_pf;
    logic [23:0]      shadow_pf_next;
    logic [23:0]      active_pf;
    logic [1:0]       shadow_mode;
    logic [1:0]       mode_next;
    logic [1:0]       active_mode;
    logic [7:0]       col [9];
    logic             pending;
    logic             vblank_q;
    logic             vb_rise;
    logic             pf_wr;
    logic             mode_wr;
    logic             col_wr;
    logic [3:0]       col_idx;
    logic [7:0]       rd_data;
    pf_state_t        state;
    logic [IDX_W-1:0] bit_idx;
    logic [4:0]       pf_idx;
    logic             pf_bit;

    assign vb_rise = in_vblank & ~vblank_q;
    assign pf_wr   = write_enable && (address <= ADDR_PF2);
    assign mode_wr = write_enable && (address == ADDR_MODE);
    assign col_wr  = write_enable && (address >= ADDR_FG_R) && (address <= ADDR_BORDER_B);
    assign col_idx = 4'(address - ADDR_FG_R);
    assign pf_idx  = 5'(bit_idx);
    assign pf_bit  = active_pf[pf_idx];

    // Shadow contents as they will be after this cycle's write, so a copy can include it
    always_comb begin
        shadow_pf_next = shadow_pf;
        mode_next      = mode_wr ? data_in[1:0] : shadow_mode;
        if (pf_wr) begin
            case (address[1:0])
                2'd0:    shadow_pf_next[7:0]   = data_in;
                2'd1:    shadow_pf_next[15:8]  = data_in;
                default: shadow_pf_next[23:16] = data_in;
            endcase
        end
    end

    // Software-visible register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_pf   <= '0;
            shadow_mode <= '0;
            for (int i = 0; i < 9; i++) begin
                col[i] <= '0;
            end
        end else begin
            shadow_pf   <= shadow_pf_next;
            shadow_mode <= mode_next;
            if (col_wr) begin
                col[col_idx] <= data_in;
            end
        end
    end

    // Active copy: taken at the vblank rising edge, or immediately in IMMEDIATE mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_pf   <= '0;
            active_mode <= '0;
            pending     <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            vblank_q <= in_vblank;
            if (vb_rise && (pending || pf_wr)) begin
                active_pf   <= shadow_pf_next;
                active_mode <= mode_next;
                pending     <= 1'b0;
            end else if (pf_wr) begin
                if (shadow_mode[MODE_IMMEDIATE]) begin
                    active_pf <= shadow_pf_next;
                end else begin
                    pending <= 1'b1;
                end
            end
        end
    end

    // Read mux; status is always visible, the rest only with readback built in
    always_comb begin
        rd_data = 8'h00;
`ifdef PLAYFIELD_READBACK_EN
        case (address)
            ADDR_PF0:  rd_data = shadow_pf[7:0];
            ADDR_PF1:  rd_data = shadow_pf[15:8];
            ADDR_PF2:  rd_data = shadow_pf[23:16];
            ADDR_MODE: rd_data = {6'b0, shadow_mode};
            default: begin
                if ((address >= ADDR_FG_R) && (address <= ADDR_BORDER_B)) begin
                    rd_data = col[col_idx];
                end
            end
        endcase
`endif
        if (address == ADDR_STATUS) begin
            rd_data = {6'b0, in_vblank, pending};
        end
    end

    // Read data register, loaded only on a read cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (enable && !write_enable) begin
            data_out <= rd_data;
        end
    end

    playfield_timing #(
        .PF_BITS   (PF_BITS),
        .BIT_WIDTH (BIT_WIDTH),
        .BORDER    (BORDER),
        .HPOS_W    (HPOS_W),
        .IDX_W     (IDX_W)
    ) u_timing (
        .clk      (clk),
        .reset_n  (reset_n),
        .hpos     (hpos),
        .in_image (in_image),
        .reflect  (active_mode[MODE_REFLECT]),
        .state    (state),
        .bit_idx  (bit_idx)
    );

    // Registered colour: border colour at the edges, fg/bg by playfield bit, black when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            case (state)
                ST_LEFT, ST_RIGHT: begin
                    red   <= pf_bit ? col[0] : col[3];
                    green <= pf_bit ? col[1] : col[4];
                    blue  <= pf_bit ? col[2] : col[5];
                end
                ST_BORDER_L, ST_BORDER_R: begin
                    red   <= col[6];
                    green <= col[7];
                    blue  <= col[8];
                end
                default: begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playfield_gen.sv
// tb/tb_playfield_gen.sv - directed self-checking bench for playfield_gen
module tb_playfield_gen;

    localparam int PF_BITS  = 22;
    localparam int BW       = 16;
    localparam int BRD      = 8;
    localparam int LINE_H   = 720;
    localparam logic [23:0] FG  = 24'h112233;
    localparam logic [23:0] BG  = 24'h445566;
    localparam logic [23:0] BRC = 24'h778899;
`ifdef PLAYFIELD_READBACK_EN
    localparam logic [7:0] RB_EXP = 8'hA5;
`else
    localparam logic [7:0] RB_EXP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       write_enable;
    logic [5:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [9:0] hpos;
    logic       in_image;
    logic       in_vblank;
    logic [7:0] red, green, blue;
    logic [23:0] rgb;

    int errors = 0;
    int checks = 0;

    int         wq_h[$];
    logic [5:0] wq_a[$];
    logic [7:0] wq_d[$];

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    playfield_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
        .hpos         (hpos),
        .in_image     (in_image),
        .in_vblank    (in_vblank),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
        write_enable = 1'b1;
        address      = a;
        data_in      = d;
        step();
        write_enable = 1'b0;
    endtask

    task automatic reg_read_check(input logic [5:0] a, input logic [7:0] exp, input string name);
        enable  = 1'b1;
        address = a;
        step();
        enable  = 1'b0;
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%02h expected %02h", name, data_out, exp);
        end
    endtask

    task automatic pulse_vblank();
        in_vblank = 1'b1;
        step();
        in_vblank = 1'b0;
        step();
    endtask

    task automatic apply_hook(input int h);
        if (wq_h.size() > 0 && wq_h[0] == h) begin
            write_enable = 1'b1;
            address      = wq_a.pop_front();
            data_in      = wq_d.pop_front();
            void'(wq_h.pop_front());
        end else begin
            write_enable = 1'b0;
        end
    endtask

    function automatic logic [23:0] exp_pix(input int p, input logic [23:0] pf, input bit refl);
        int j;
        int b;
        if (p < BRD) return BRC;
        if (p < BRD + PF_BITS * BW) return pf[(p - BRD) / BW] ? FG : BG;
        if (p < BRD + 2 * PF_BITS * BW) begin
            j = (p - BRD - PF_BITS * BW) / BW;
            b = refl ? (PF_BITS - 1 - j) : j;
            return pf[b] ? FG : BG;
        end
        return BRC;
    endfunction

    task automatic end_line(input string name);
        write_enable = 1'b0;
        in_image     = 1'b0;
        hpos         = 10'd800;
        step();
        step();
        step();
        checks++;
        if (rgb !== 24'h0) begin
            errors++;
            $display("FAIL %s_idle: rgb=%06h expected 000000", name, rgb);
        end
    endtask

    task automatic render_line(input logic [23:0] pf, input bit refl, input string name);
        int bad = 0;
        int fp = 0;
        logic [23:0] fa = '0;
        logic [23:0] fe = '0;
        logic [23:0] e;
        for (int h = 0; h < LINE_H; h++) begin
            hpos     = 10'(h);
            in_image = 1'b1;
            apply_hook(h);
            step();
            if (h >= 1) begin
                e = exp_pix(h - 1, pf, refl);
                if (rgb !== e) begin
                    if (bad == 0) begin
                        fp = h - 1;
                        fa = rgb;
                        fe = e;
                    end
                    bad++;
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s: %0d pixels wrong, first pixel %0d rgb=%06h expected %06h", name, bad, fp, fa, fe);
        end
        end_line(name);
    endtask

    task automatic test_reset();
        checks++;
        if (rgb !== 24'h0) begin
            errors++;
            $display("FAIL reset_rgb: rgb=%06h expected 000000", rgb);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out: data_out=%02h expected 00", data_out);
        end
        reset_n = 1'b1;
        step();
        reg_read_check(6'h0d, 8'h00, "reset_status");
    endtask

    task automatic test_readback();
        reg_write(6'h04, 8'hA5);
        reg_read_check(6'h04, RB_EXP, "readback_fg_r");
    endtask

    task automatic setup_colours();
        reg_write(6'h04, FG[23:16]);
        reg_write(6'h05, FG[15:8]);
        reg_write(6'h06, FG[7:0]);
        reg_write(6'h07, BG[23:16]);
        reg_write(6'h08, BG[15:8]);
        reg_write(6'h09, BG[7:0]);
        reg_write(6'h0a, BRC[23:16]);
        reg_write(6'h0b, BRC[15:8]);
        reg_write(6'h0c, BRC[7:0]);
    endtask

    task automatic test_reflect();
        reg_write(6'h00, 8'h01);
        reg_write(6'h01, 8'h00);
        reg_write(6'h02, 8'h00);
        reg_write(6'h03, 8'h01);
        reg_read_check(6'h0d, 8'h01, "status_pending");
        step();
        step();
        step();
        checks++;
        if (data_out !== 8'h01) begin
            errors++;
            $display("FAIL read_hold: data_out=%02h expected 01", data_out);
        end
        reg_read_check(6'h3f, 8'h00, "read_unmapped");
        in_vblank = 1'b1;
        step();
        step();
        reg_read_check(6'h0d, 8'h02, "status_in_vblank");
        in_vblank = 1'b0;
        step();
        render_line(24'h000001, 1'b1, "line_reflect");
    endtask

    task automatic test_no_reflect();
        reg_write(6'h03, 8'h00);
        reg_write(6'h00, 8'h01);
        pulse_vblank();
        reg_read_check(6'h0d, 8'h00, "status_after_copy");
        render_line(24'h000001, 1'b0, "line_noreflect");
    endtask

    task automatic test_midline_write();
        wq_h.push_back(100);
        wq_a.push_back(6'h01);
        wq_d.push_back(8'h02);
        render_line(24'h000001, 1'b0, "line_midline_old");
        reg_read_check(6'h0d, 8'h01, "status_midline_pending");
        pulse_vblank();
        reg_read_check(6'h0d, 8'h00, "status_midline_cleared");
        render_line(24'h000201, 1'b0, "line_midline_new");
    endtask

    task automatic test_back_to_back();
        in_vblank    = 1'b1;
        write_enable = 1'b1;
        address      = 6'h00;
        data_in      = 8'h80;
        step();
        write_enable = 1'b0;
        step();
        reg_read_check(6'h0d, 8'h02, "status_same_cycle");
        in_vblank = 1'b0;
        step();
        render_line(24'h000280, 1'b0, "line_same_cycle");
    endtask

    task automatic test_immediate();
        reg_write(6'h03, 8'h02);
        reg_write(6'h02, 8'h20);
        reg_read_check(6'h0d, 8'h00, "status_immediate");
        render_line(24'h200280, 1'b0, "line_immediate");
    endtask

    task automatic test_reset_midline();
        int bad = 0;
        int fp = 0;
        logic [23:0] fa = '0;
        reg_write(6'h03, 8'h00);
        reg_write(6'h01, 8'hFF);
        reg_read_check(6'h0d, 8'h01, "status_before_reset");
        for (int i = 0; i < 9; i++) begin
            wq_h.push_back(110 + i);
            wq_a.push_back(6'(4 + i));
        end
        wq_d.push_back(FG[23:16]);
        wq_d.push_back(FG[15:8]);
        wq_d.push_back(FG[7:0]);
        wq_d.push_back(BG[23:16]);
        wq_d.push_back(BG[15:8]);
        wq_d.push_back(BG[7:0]);
        wq_d.push_back(BRC[23:16]);
        wq_d.push_back(BRC[15:8]);
        wq_d.push_back(BRC[7:0]);
        for (int h = 0; h < LINE_H; h++) begin
            hpos     = 10'(h);
            in_image = 1'b1;
            apply_hook(h);
            if (h == 100) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if (rgb !== 24'h0) begin
                    errors++;
                    $display("FAIL reset_async_rgb: rgb=%06h expected 000000", rgb);
                end
                checks++;
                if (data_out !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_async_data_out: data_out=%02h expected 00", data_out);
                end
            end
            if (h == 103) reset_n = 1'b1;
            step();
            if (h > 100 && rgb !== 24'h0) begin
                if (bad == 0) begin
                    fp = h - 1;
                    fa = rgb;
                end
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_render: %0d pixels wrong, first pixel %0d rgb=%06h expected 000000", bad, fp, fa);
        end
        end_line("reset_line");
        reg_read_check(6'h0d, 8'h00, "status_after_reset");
        render_line(24'h000000, 1'b0, "line_after_reset");
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        write_enable = 1'b0;
        address      = 6'h00;
        data_in      = 8'h00;
        hpos         = 10'd0;
        in_image     = 1'b0;
        in_vblank    = 1'b0;
        step();
        step();
        test_reset();
        test_readback();
        setup_colours();
        test_reflect();
        test_no_reflect();
        test_midline_write();
        test_back_to_back();
        test_immediate();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
